fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program-counter and fetch stage directly upstream of the instruction memory.
//  Drives the instruction memory byte address and captures the returned word into an instruction register (IR) for decode.
//  Applies branch/jal/jalr redirects issued for the instruction in the IR and squashes the wrong-path fetch.
//  Flags misaligned or out-of-range fetch targets as a sticky fault.
// PARAMETERS
//  Width       32    datapath / address width
//  RESET_PC    0     PC value loaded on reset (byte address, multiple of 4)
//  IMEM_DEPTH  512   instruction memory entries; legal fetch address < IMEM_DEPTH
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  stall        in   1      hold all fetch state this cycle
//  pc_sel       in   2      00 seq, 01 branch, 10 jal, 11 jalr (qualifies IR instruction)
//  branch_taken in   1      branch condition result (used only when pc_sel=01)
//  imm          in   Width  sign-extended immediate of IR instruction
//  rs1_data     in   Width  rs1 operand for jalr
//  imem_addr    out  Width  byte address to instruction memory (= pc)
//  imem_rd      in   Width  instruction word returned combinationally for imem_addr
//  instr        out  Width  IR: fetched instruction
//  instr_pc     out  Width  address instr was fetched from
//  instr_valid  out  1      IR holds a live instruction
//  pc_plus4     out  Width  instr_pc + 4 (link value for jal/jalr)
//  fetch_count  out  32     number of valid instructions loaded into IR
//  fault        out  1      sticky fetch fault
//  fault_pc     out  Width  offending target address
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - pc=RESET_PC; instr=32'h00000013 (nop); instr_pc=0; instr_valid=0; fetch_count=0; fault=0; fault_pc=0; state=RUN.
//  States: RUN, FAULT.
//   - RUN->FAULT on an illegal target.
//   - FAULT is left only by rst.
//  Target computation (combinational, relative to instr_pc):
//   - br/jal: instr_pc+imm. jalr: (rs1_data+imm) & ~1.
//   - Width-bit arithmetic; carry discarded.
//  Redirect: instr_valid=1 and (pc_sel=10 | pc_sel=11 | (pc_sel=01 & branch_taken)).
//  Per edge in RUN, priority rst > stall > redirect > sequential:
//   - stall=1: pc, instr, instr_pc, instr_valid, fetch_count hold. Redirect inputs are ignored; the issuer keeps them asserted.
//   - redirect, legal target: pc<=target; instr_valid<=0 (one-cycle bubble squashes the word at pc); instr holds.
//   - sequential: instr<=imem_rd; instr_pc<=pc; instr_valid<=1; fetch_count+=1 (wraps 2^32-1 -> 0).
//     If pc+4 is legal then pc<=pc+4, else enter FAULT with fault_pc=pc+4.
//     The word at pc is still loaded.
//   - Illegal target: target[1:0]!=0, or target >= IMEM_DEPTH (covers 32-bit wrap).
//     Illegal redirect: FAULT, fault<=1, fault_pc<=target, instr_valid<=0.
//  In FAULT: pc holds; on the first non-stalled edge instr_valid<=0, and it stays 0; fetch_count holds.
//  Latency:
//   - imem_addr=pc combinationally.
//   - The word appears in the IR 1 cycle later.
//   - A redirect costs exactly 1 bubble cycle.
//   - Branch not taken costs 0 bubbles.
//  Outputs are register-driven except imem_addr and pc_plus4 (pure functions of registers).
// TESTING
//  1. rst high 2 cycles, release with imem[0]=0x002081B3 -> imem_addr 0,4,8; next cycle instr=0x002081B3, instr_pc=0, valid=1, count=1.
//  2. IR pc=24, pc_sel=01, taken=1, imm=8 -> pc=32, valid=0 one cycle, then instr_pc=32; taken=0 -> instr_pc=28, no bubble.
//  3. jalr rs1=0x13, imm=2 -> target 0x14, instr_pc=20 after bubble, pc_plus4 before = IR pc+4; rs1=2, imm=0 -> fault=1, fault_pc=2.
//  4. stall=1 for 3 cycles mid-run -> imem_addr, instr, instr_pc, instr_valid, fetch_count unchanged; redirect during stall ignored.
//  5. RESET_PC=508, IMEM_DEPTH=512 -> word at 508 loaded valid, fault=1, fault_pc=512, then instr_valid=0.
//  6. rst asserted while in FAULT -> next edge all reset values, pc=RESET_PC, fault=0, fetch resumes.

Source files
------------

// File: rtl/fetch_unit.sv
// Program counter and fetch stage: drives the instruction memory address, loads the
// instruction register, applies branch/jal/jalr redirects and traps illegal fetch targets.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal fetch: sequential advance or redirect from IR instruction
// FAULT | illegal target seen; pc frozen, IR drained, left only by rst

module fetch_unit #(
    parameter int          Width      = 32,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned IMEM_DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       pc_sel,
    input  logic             branch_taken,
    input  logic [Width-1:0] imm,
    input  logic [Width-1:0] rs1_data,
    output logic [Width-1:0] imem_addr,
    input  logic [Width-1:0] imem_rd,
    output logic [Width-1:0] instr,
    output logic [Width-1:0] instr_pc,
    output logic             instr_valid,
    output logic [Width-1:0] pc_plus4,
    output logic [31:0]      fetch_count,
    output logic             fault,
    output logic [Width-1:0] fault_pc
);

    localparam logic [Width-1:0] RESET_PC_W = Width'(RESET_PC);
    localparam logic [Width-1:0] DEPTH_W    = Width'(IMEM_DEPTH);
    localparam logic [Width-1:0] NOP_W      = Width'(32'h0000_0013);
    localparam logic [Width-1:0] FOUR_W     = Width'(4);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [Width-1:0] pc, pc_nxt;
    logic [Width-1:0] instr_nxt, instr_pc_nxt, fault_pc_nxt;
    logic             instr_valid_nxt, fault_nxt;
    logic [31:0]      fetch_count_nxt;

    logic [Width-1:0] jalr_sum, target, seq_pc;
    logic             redirect, target_bad, seq_bad;

    // A target past the end of memory also catches sums that wrapped through 2^Width.
    function automatic logic illegal_addr(input logic [Width-1:0] a);
        return (a[1:0] != 2'b00) || (a >= DEPTH_W);
    endfunction

    assign imem_addr = pc;
    assign pc_plus4  = instr_pc + FOUR_W;
    assign seq_pc    = pc + FOUR_W;
    assign jalr_sum  = rs1_data + imm;

    always_comb begin
        target = instr_pc + imm;
        if (pc_sel == 2'b11) begin
            target = {jalr_sum[Width-1:1], 1'b0};
        end
    end

    assign redirect   = instr_valid &&
                        ((pc_sel == 2'b10) || (pc_sel == 2'b11) ||
                         ((pc_sel == 2'b01) && branch_taken));
    assign target_bad = illegal_addr(target);
    assign seq_bad    = illegal_addr(seq_pc);

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        instr_nxt       = instr;
        instr_pc_nxt    = instr_pc;
        instr_valid_nxt = instr_valid;
        fetch_count_nxt = fetch_count;
        fault_nxt       = fault;
        fault_pc_nxt    = fault_pc;

        if (!stall) begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        // The word currently at pc is wrong-path; the bubble discards it.
                        instr_valid_nxt = 1'b0;
                        if (target_bad) begin
                            state_nxt    = FAULT;
                            fault_nxt    = 1'b1;
                            fault_pc_nxt = target;
                        end else begin
                            pc_nxt = target;
                        end
                    end else begin
                        instr_nxt       = imem_rd;
                        instr_pc_nxt    = pc;
                        instr_valid_nxt = 1'b1;
                        fetch_count_nxt = fetch_count + 32'd1;
                        if (seq_bad) begin
                            state_nxt    = FAULT;
                            fault_nxt    = 1'b1;
                            fault_pc_nxt = seq_pc;
                        end else begin
                            pc_nxt = seq_pc;
                        end
                    end
                end
                FAULT: begin
                    instr_valid_nxt = 1'b0;
                end
                default: begin
                    state_nxt = FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC_W;
            instr       <= NOP_W;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
            fault       <= 1'b0;
            fault_pc    <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
            instr_valid <= instr_valid_nxt;
            fetch_count <= fetch_count_nxt;
            fault       <= fault_nxt;
            fault_pc    <= fault_pc_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-by-cycle vector table on a RESET_PC=0 instance,
// plus a short hand sequence on a RESET_PC=508 instance for the end-of-memory fault.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, rst2, stall, branch_taken;
    logic [1:0]  pc_sel;
    logic [31:0] imm, rs1_data;

    logic [31:0] imem_addr, imem_rd, instr, instr_pc, pc_plus4, fetch_count, fault_pc;
    logic        instr_valid, fault;
    logic [31:0] imem_addr2, imem_rd2, instr2, instr_pc2, pc_plus42, fetch_count2, fault_pc2;
    logic        instr_valid2, fault2;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h0020_81B3;
        return 32'hC0DE_0000 | a;
    endfunction

    assign imem_rd  = imem_word(imem_addr);
    assign imem_rd2 = imem_word(imem_addr2);

    fetch_unit #(.Width(32), .RESET_PC(0), .IMEM_DEPTH(512)) dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .branch_taken(branch_taken),
        .imm(imm), .rs1_data(rs1_data), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .pc_plus4(pc_plus4),
        .fetch_count(fetch_count), .fault(fault), .fault_pc(fault_pc)
    );

    fetch_unit #(.Width(32), .RESET_PC(508), .IMEM_DEPTH(512)) dut2 (
        .clk(clk), .rst(rst2), .stall(stall), .pc_sel(pc_sel), .branch_taken(branch_taken),
        .imm(imm), .rs1_data(rs1_data), .imem_addr(imem_addr2), .imem_rd(imem_rd2),
        .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2), .pc_plus4(pc_plus42),
        .fetch_count(fetch_count2), .fault(fault2), .fault_pc(fault_pc2)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic [1:0]  sel;
        logic        tk;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        valid;
        logic [31:0] cnt;
        logic        flt;
        logic [31:0] fpc;
    } vec_t;

    localparam int NVEC = 28;
    localparam logic [31:0] NOP = 32'h0000_0013;
    vec_t vecs[NVEC];

    task automatic check_vec(input int idx, input vec_t v);
        logic [31:0] exp_pp4;
        exp_pp4 = v.ipc + 32'd4;
        vec_cnt++;
        if (imem_addr !== v.addr || instr !== v.instr || instr_pc !== v.ipc ||
            instr_valid !== v.valid || fetch_count !== v.cnt || fault !== v.flt ||
            fault_pc !== v.fpc || pc_plus4 !== exp_pp4) begin
            err_cnt++;
            $display("FAIL vec%0d (got/exp): addr=%h/%h instr=%h/%h ipc=%h/%h valid=%b/%b cnt=%0d/%0d fault=%b/%b fpc=%h/%h pp4=%h/%h",
                     idx, imem_addr, v.addr, instr, v.instr, instr_pc, v.ipc, instr_valid, v.valid,
                     fetch_count, v.cnt, fault, v.flt, fault_pc, v.fpc, pc_plus4, exp_pp4);
        end
    endtask

    task automatic check2(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        //            rst stl sel tk imm           rs1    addr  instr            ipc v  cnt flt fpc
        vecs[0]  = '{1, 0, 2'd0, 0, 32'd0,        32'd0, 32'd0,  NOP,            32'd0,  0, 32'd0,  0, 32'd0};
        vecs[1]  = '{1, 0, 2'd0, 0, 32'd0,        32'd0, 32'd0,  NOP,            32'd0,  0, 32'd0,  0, 32'd0};
        vecs[2]  = '{0, 0, 2'd0, 0, 32'd0,        32'd0, 32'd4,  imem_word(0),   32'd0,  1, 32'd1,  0, 32'd0};
        vecs[3]  = '{0, 0, 2'd0, 0, 32'd0,        32'd0, 32'd8,  imem_word(4),   32'd4,  1, 32'd2,  0, 32'd0};
        vecs[4]  = '{0, 0, 2'd0, 0, 32'd0,        32'd0, 32'd12, imem_word(8),   32'd8,  1, 32'd3,  0, 32'd0};
        vecs[5]  = '{0, 0, 2'd0, 0, 32'd0,        32'd0, 32'd16, imem_word(12),  32'd12, 1, 32'd4,  0, 32'd0};
        vecs[6]  = '{0, 0, 2'd0, 0, 32'd0,        32'd0, 32'd20, imem_word(16),  32'd16, 1, 32'd5,  0, 32'd0};
        vecs[7]  = '{0, 0, 2'd0, 0, 32'd0,        32'd0, 32'd24, imem_word(20),  32'd20, 1, 32'd6,  0, 32'd0};
        vecs[8]  = '{0, 0, 2'd0, 0, 32'd0,        32'd0, 32'd28, imem_word(24),  32'd24, 1, 32'd7,  0, 32'd0};
        // taken branch from IR pc 24, +8 -> 32 with one bubble
        vecs[9]  = '{0, 0, 2'd1, 1, 32'd8,        32'd0, 32'd32, imem_word(24),  32'd24, 0, 32'd7,  0, 32'd0};
        // issuer still asserting during the bubble: no redirect since IR is not valid
        vecs[10] = '{0, 0, 2'd1, 1, 32'd8,        32'd0, 32'd36, imem_word(32),  32'd32, 1, 32'd8,  0, 32'd0};
        vecs[11] = '{0, 0, 2'd1, 0, 32'd8,        32'd0, 32'd40, imem_word(36),  32'd36, 1, 32'd9,  0, 32'd0};
        // jal backwards: 36 - 8 = 28
        vecs[12] = '{0, 0, 2'd2, 0, 32'hFFFF_FFF8, 32'd0, 32'd28, imem_word(36), 32'd36, 0, 32'd9,  0, 32'd0};
        vecs[13] = '{0, 0, 2'd0, 0, 32'd0,        32'd0, 32'd32, imem_word(28),  32'd28, 1, 32'd10, 0, 32'd0};
        // jalr: (0x13 + 2) & ~1 = 0x14
        vecs[14] = '{0, 0, 2'd3, 0, 32'd2,        32'h13, 32'd20, imem_word(28), 32'd28, 0, 32'd10, 0, 32'd0};
        vecs[15] = '{0, 0, 2'd0, 0, 32'd0,        32'd0, 32'd24, imem_word(20),  32'd20, 1, 32'd11, 0, 32'd0};
        // stall 3 cycles with a jal presented: everything holds
        vecs[16] = '{0, 1, 2'd2, 0, 32'd100,      32'd0, 32'd24, imem_word(20),  32'd20, 1, 32'd11, 0, 32'd0};
        vecs[17] = '{0, 1, 2'd2, 0, 32'd100,      32'd0, 32'd24, imem_word(20),  32'd20, 1, 32'd11, 0, 32'd0};
        vecs[18] = '{0, 1, 2'd2, 0, 32'd100,      32'd0, 32'd24, imem_word(20),  32'd20, 1, 32'd11, 0, 32'd0};
        vecs[19] = '{0, 0, 2'd0, 0, 32'd0,        32'd0, 32'd28, imem_word(24),  32'd24, 1, 32'd12, 0, 32'd0};
        // jalr to 2: misaligned -> fault, pc holds
        vecs[20] = '{0, 0, 2'd3, 0, 32'd0,        32'd2, 32'd28, imem_word(24),  32'd24, 0, 32'd12, 1, 32'd2};
        vecs[21] = '{0, 0, 2'd0, 0, 32'd0,        32'd0, 32'd28, imem_word(24),  32'd24, 0, 32'd12, 1, 32'd2};
        vecs[22] = '{0, 1, 2'd0, 0, 32'd0,        32'd0, 32'd28, imem_word(24),  32'd24, 0, 32'd12, 1, 32'd2};
        // reset out of FAULT, fetch resumes
        vecs[23] = '{1, 0, 2'd0, 0, 32'd0,        32'd0, 32'd0,  NOP,            32'd0,  0, 32'd0,  0, 32'd0};
        vecs[24] = '{0, 0, 2'd0, 0, 32'd0,        32'd0, 32'd4,  imem_word(0),   32'd0,  1, 32'd1,  0, 32'd0};
        // jal to 512: out of range
        vecs[25] = '{0, 0, 2'd2, 0, 32'h200,      32'd0, 32'd4,  imem_word(0),   32'd0,  0, 32'd1,  1, 32'd512};
        // rst wins over stall
        vecs[26] = '{1, 1, 2'd0, 0, 32'd0,        32'd0, 32'd0,  NOP,            32'd0,  0, 32'd0,  0, 32'd0};
        vecs[27] = '{0, 0, 2'd0, 0, 32'd0,        32'd0, 32'd4,  imem_word(0),   32'd0,  1, 32'd1,  0, 32'd0};

        rst2 = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            rst          = vecs[i].rst;
            stall        = vecs[i].stall;
            pc_sel       = vecs[i].sel;
            branch_taken = vecs[i].tk;
            imm          = vecs[i].imm;
            rs1_data     = vecs[i].rs1;
            @(posedge clk);
            #1;
            check_vec(i, vecs[i]);
        end

        // End-of-memory sequential fault on the RESET_PC=508 instance
        stall = 1'b0; pc_sel = 2'd0; branch_taken = 1'b0; imm = '0; rs1_data = '0;
        rst2 = 1'b1;
        @(posedge clk); #1;
        check2("r508_reset_addr",  imem_addr2, 32'd508);
        check2("r508_reset_fault", {31'd0, fault2}, 32'd0);
        rst2 = 1'b0;
        @(posedge clk); #1;
        check2("r508_instr",  instr2, imem_word(32'd508));
        check2("r508_ipc",    instr_pc2, 32'd508);
        check2("r508_valid",  {31'd0, instr_valid2}, 32'd1);
        check2("r508_count",  fetch_count2, 32'd1);
        check2("r508_fault",  {31'd0, fault2}, 32'd1);
        check2("r508_fpc",    fault_pc2, 32'd512);
        check2("r508_addr",   imem_addr2, 32'd508);
        @(posedge clk); #1;
        check2("r508_drain_valid", {31'd0, instr_valid2}, 32'd0);
        check2("r508_drain_count", fetch_count2, 32'd1);
        check2("r508_drain_addr",  imem_addr2, 32'd508);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
